// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory read port, execute redirect, and decode stream.
// Stream handshake: fetchValid/fetchPc/fetchInstruction are stable while fetchValid is high and
// fetchReady is low; a transfer happens on every rising edge where fetchValid && fetchReady.
interface instruction_fetch_unit_if;
  logic [31:0] programCounter;
  logic [31:0] instructionData;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        fetchValid;
  logic [31:0] fetchInstruction;
  logic [31:0] fetchPc;
  logic        fetchReady;
  logic        fetchFault;

  modport master (
    output programCounter,
    input  instructionData,
    input  redirectValid,
    input  redirectTarget,
    output fetchValid,
    output fetchInstruction,
    output fetchPc,
    input  fetchReady,
    output fetchFault
  );

  modport slave (
    input  programCounter,
    output instructionData,
    output redirectValid,
    output redirectTarget,
    input  fetchValid,
    input  fetchInstruction,
    input  fetchPc,
    output fetchReady,
    input  fetchFault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, queues {pc, instr} pairs for decode, flushes on redirect.
// Optional FETCH_BOUND_CHECK_EN stops fetch with a sticky fault when pc leaves the 4 KiB memory.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  logic [31:0] r_pc;
  logic [31:0] r_q_pc    [4];
  logic [31:0] r_q_instr [4];
  logic [1:0]  r_head;
  logic [1:0]  r_tail;
  logic [2:0]  r_count;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;

  logic        w_pop;
  logic        w_room;
  logic        w_try;
  logic        w_push;
  logic        w_oob;
  logic        w_fault;
  logic        w_fault_set;
  logic [1:0]  w_head_next;
  logic [2:0]  w_count_next;
  logic        w_take_new;
  logic [31:0] w_next_pc;
  logic [31:0] w_next_instr;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(QUEUE_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef FETCH_BOUND_CHECK_EN
  logic r_fault;
  assign w_oob   = (r_pc[31:12] != 20'd0);
  assign w_fault = r_fault;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  r_fault <= 1'b0;
    else if (bus.redirectValid) r_fault <= 1'b0;
    else if (w_fault_set)       r_fault <= 1'b1;
  end
`else
  assign w_oob   = 1'b0;
  assign w_fault = 1'b0;
`endif

  always_comb begin
    w_pop        = (r_count != 3'd0) && bus.fetchReady;
    w_room       = (r_count < 3'(QUEUE_DEPTH)) || w_pop;
    w_try        = w_room && !w_fault && !bus.redirectValid;
    w_push       = w_try && !w_oob;
    w_fault_set  = w_try && w_oob;
    w_head_next  = w_pop ? ptr_inc(r_head) : r_head;
    w_count_next = bus.redirectValid ? 3'd0
                 : r_count + 3'(w_push) - 3'(w_pop);
    // A push landing in the next head slot means the queue holds only that new word.
    w_take_new   = w_push && (r_tail == w_head_next);
    w_next_pc    = w_take_new ? r_pc : r_q_pc[w_head_next];
    w_next_instr = w_take_new ? bus.instructionData : r_q_instr[w_head_next];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_head      <= 2'd0;
      r_tail      <= 2'd0;
      r_count     <= 3'd0;
      r_out_pc    <= 32'd0;
      r_out_instr <= 32'd0;
    end else begin
      if (bus.redirectValid) begin
        r_pc   <= {bus.redirectTarget[31:2], 2'b00};
        r_head <= 2'd0;
        r_tail <= 2'd0;
      end else begin
        r_head <= w_head_next;
        if (w_push) begin
          r_tail <= ptr_inc(r_tail);
          r_pc   <= r_pc + 32'd4;
        end
      end
      r_count <= w_count_next;
      // Head copies only move when a word is present, so they hold while the queue is empty.
      if (w_count_next != 3'd0) begin
        r_out_pc    <= w_next_pc;
        r_out_instr <= w_next_instr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_pc[r_tail]    <= r_pc;
      r_q_instr[r_tail] <= bus.instructionData;
    end
  end

  assign bus.programCounter   = r_pc;
  assign bus.fetchValid       = (r_count != 3'd0);
  assign bus.fetchPc          = r_out_pc;
  assign bus.fetchInstruction = r_out_instr;
  assign bus.fetchFault       = w_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model (word i = 0xA000_0000 + i).
module tb_instruction_fetch_unit;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // 1024-word memory; upper address bits alias.
  always_comb bus.instructionData = 32'hA000_0000 + {22'd0, bus.programCounter[11:2]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check_eq({tag, "_valid"}, {31'd0, bus.fetchValid}, 32'd1);
    check_eq({tag, "_pc"}, bus.fetchPc, pc);
    check_eq({tag, "_instr"}, bus.fetchInstruction, instr);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset              = 1'b1;
    bus.fetchReady     = 1'b1;
    bus.redirectValid  = 1'b0;
    bus.redirectTarget = 32'd0;

    #12;
    check_eq("rst_valid", {31'd0, bus.fetchValid}, 32'd0);
    check_eq("rst_pc_out", bus.programCounter, 32'd0);
    check_eq("rst_fetch_pc", bus.fetchPc, 32'd0);
    check_eq("rst_fetch_instr", bus.fetchInstruction, 32'd0);
    check_eq("rst_fault", {31'd0, bus.fetchFault}, 32'd0);

    @(negedge clock);
    reset = 1'b0;

    // Streaming with no gaps
    for (int k = 0; k < 4; k++) begin
      step();
      check_head($sformatf("stream%0d", k), 32'(4 * k), 32'hA000_0000 + 32'(k));
    end

    // Asynchronous reset between edges
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_rst_valid", {31'd0, bus.fetchValid}, 32'd0);
    check_eq("async_rst_pc", bus.programCounter, 32'd0);
    bus.fetchReady = 1'b0;
    reset = 1'b0;

    // Backpressure: queue fills with 0,4 and PC parks at 8
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("bp_head%0d", k), bus.fetchPc, 32'd0);
    end
    check_eq("bp_valid", {31'd0, bus.fetchValid}, 32'd1);
    check_eq("bp_pc_hold", bus.programCounter, 32'd8);
    bus.fetchReady = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      check_head($sformatf("release%0d", k), 32'(4 * k), 32'hA000_0000 + 32'(k));
    end

    // Redirect with a full queue
    bus.fetchReady = 1'b0;
    step();
    step();
    bus.redirectValid  = 1'b1;
    bus.redirectTarget = 32'h0000_0103;
    step();
    bus.redirectValid = 1'b0;
    bus.fetchReady    = 1'b1;
    check_eq("redir_valid_low", {31'd0, bus.fetchValid}, 32'd0);
    check_eq("redir_pc", bus.programCounter, 32'h0000_0100);
    step();
    check_head("redir_first", 32'h0000_0100, 32'hA000_0040);
    step();
    check_head("redir_second", 32'h0000_0104, 32'hA000_0041);

`ifdef FETCH_BOUND_CHECK_EN
    bus.redirectValid  = 1'b1;
    bus.redirectTarget = 32'h0000_0FFC;
    step();
    bus.redirectValid = 1'b0;
    check_eq("bound_redir_valid", {31'd0, bus.fetchValid}, 32'd0);
    step();
    check_head("bound_last_word", 32'h0000_0FFC, 32'hA000_03FF);
    check_eq("bound_no_fault_yet", {31'd0, bus.fetchFault}, 32'd0);
    step();
    check_eq("bound_fault", {31'd0, bus.fetchFault}, 32'd1);
    check_eq("bound_valid_low", {31'd0, bus.fetchValid}, 32'd0);
    check_eq("bound_pc_hold", bus.fetchPc, 32'h0000_0FFC);
    step();
    check_eq("bound_fault_sticky", {31'd0, bus.fetchFault}, 32'd1);
    bus.redirectValid  = 1'b1;
    bus.redirectTarget = 32'h0000_0000;
    step();
    bus.redirectValid = 1'b0;
    check_eq("bound_fault_clear", {31'd0, bus.fetchFault}, 32'd0);
    check_eq("bound_resume_pc", bus.programCounter, 32'd0);
    step();
    check_head("bound_resume", 32'd0, 32'hA000_0000);
`else
    bus.redirectValid  = 1'b1;
    bus.redirectTarget = 32'hFFFF_FFFC;
    step();
    bus.redirectValid = 1'b0;
    check_eq("wrap_redir_valid", {31'd0, bus.fetchValid}, 32'd0);
    check_eq("wrap_redir_pc", bus.programCounter, 32'hFFFF_FFFC);
    step();
    check_head("wrap_top", 32'hFFFF_FFFC, 32'hA000_03FF);
    step();
    check_head("wrap_zero", 32'h0000_0000, 32'hA000_0000);
    check_eq("wrap_fault", {31'd0, bus.fetchFault}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
